// File: rtl/cond_pkg.sv
// Shared definitions for the condition-evaluation path: condition codes,
// NZCV bit positions and the flag vector type.
package cond_pkg;

    typedef logic [3:0] nzcv_t;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides whether a 4-bit
// condition field passes against a given NZCV flag vector.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  nzcv_t      Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    always_comb begin
        n = Flags[FLAG_N];
        z = Flags[FLAG_Z];
        c = Flags[FLAG_C];
        v = Flags[FLAG_V];
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
            NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Architectural NZCV register, condition gating of decoder write/branch
// requests, and a saturating debug count of condition-failed instructions.
module cond_unit
    import cond_pkg::*;
#(
    parameter int    CNT_W    = 16,
    parameter nzcv_t FLAG_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InstrValid,
    input  logic             Stall,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             SquashClr,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SquashCnt
);

    nzcv_t            flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_ex;
    logic             active;

    // Condition is judged on the registered flags so an instruction never
    // sees the flags it is itself producing.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    assign active = InstrValid & ~Stall;

    always_comb begin
        flags_d = flags_q;
        if (active & cond_ex & FlagW[1]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (active & cond_ex & FlagW[0]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    // Clear wins over a coincident squash and ignores Stall.
    always_comb begin
        cnt_d = cnt_q;
        if (SquashClr) begin
            cnt_d = '0;
        end else if (active & ~cond_ex & (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAG_RST;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign CondEx    = cond_ex;
    assign PCSrc     = PCS & cond_ex & InstrValid;
    assign RegWrite  = RegW & ~NoWrite & cond_ex & InstrValid;
    assign MemWrite  = MemW & cond_ex & InstrValid;
    assign Flags     = flags_q;
    assign SquashCnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Randomised and directed bench for cond_unit: two instances (default and a
// 4-bit counter with non-zero reset flags) checked against a behavioural model.
module tb_cond_unit;

    localparam logic [3:0] RST0 = 4'b0000;
    localparam logic [3:0] RST1 = 4'b1001;

    logic       clk;
    logic       reset_n;
    logic       InstrValid, Stall, PCS, RegW, MemW, NoWrite, SquashClr;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;

    logic        ce0, pc0, rw0, mw0;
    logic [3:0]  fl0;
    logic [15:0] sc0;
    logic        ce1, pc1, rw1, mw1;
    logic [3:0]  fl1;
    logic [3:0]  sc1;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  mflags [2];
    int unsigned mcnt   [2];
    int unsigned mmax   [2];

    cond_unit #(.CNT_W(16), .FLAG_RST(RST0)) u_dut (
        .clk(clk), .reset_n(reset_n), .InstrValid(InstrValid), .Stall(Stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .SquashClr(SquashClr),
        .CondEx(ce0), .PCSrc(pc0), .RegWrite(rw0), .MemWrite(mw0),
        .Flags(fl0), .SquashCnt(sc0)
    );

    cond_unit #(.CNT_W(4), .FLAG_RST(RST1)) u_sat (
        .clk(clk), .reset_n(reset_n), .InstrValid(InstrValid), .Stall(Stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .SquashClr(SquashClr),
        .CondEx(ce1), .PCSrc(pc1), .RegWrite(rw1), .MemWrite(mw1),
        .Flags(fl1), .SquashCnt(sc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Condition table written from the architectural definitions.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mflags[0] = RST0; mflags[1] = RST1;
        mcnt[0] = 0;      mcnt[1] = 0;
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            bit pass;
            bit go;
            pass = cond_pass(Cond, mflags[i]);
            go = InstrValid && !Stall;
            if (go && pass && FlagW[1]) mflags[i][3:2] = ALUFlags[3:2];
            if (go && pass && FlagW[0]) mflags[i][1:0] = ALUFlags[1:0];
            if (SquashClr) mcnt[i] = 0;
            else if (go && !pass && mcnt[i] < mmax[i]) mcnt[i] = mcnt[i] + 1;
        end
    endtask

    task automatic compare_all();
        bit p0, p1;
        p0 = cond_pass(Cond, mflags[0]);
        p1 = cond_pass(Cond, mflags[1]);
        check("condex0", {31'd0, ce0}, {31'd0, p0});
        check("pcsrc0",  {31'd0, pc0}, {31'd0, PCS & p0 & InstrValid});
        check("regw0",   {31'd0, rw0}, {31'd0, RegW & !NoWrite & p0 & InstrValid});
        check("memw0",   {31'd0, mw0}, {31'd0, MemW & p0 & InstrValid});
        check("flags0",  {28'd0, fl0}, {28'd0, mflags[0]});
        check("cnt0",    {16'd0, sc0}, mcnt[0]);
        check("condex1", {31'd0, ce1}, {31'd0, p1});
        check("pcsrc1",  {31'd0, pc1}, {31'd0, PCS & p1 & InstrValid});
        check("regw1",   {31'd0, rw1}, {31'd0, RegW & !NoWrite & p1 & InstrValid});
        check("memw1",   {31'd0, mw1}, {31'd0, MemW & p1 & InstrValid});
        check("flags1",  {28'd0, fl1}, {28'd0, mflags[1]});
        check("cnt1",    {28'd0, sc1}, mcnt[1]);
    endtask

    task automatic drv(input logic iv, input logic st, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                       input logic rw, input logic mw, input logic nw, input logic clr);
        InstrValid = iv; Stall = st; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; SquashClr = clr;
        #1;
    endtask

    task automatic step();
        compare_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        mmax[0] = 65535; mmax[1] = 15;
        reset_n = 1'b0;
        drv(0, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state and reset-flag evaluation
        check("rst_flags0", {28'd0, fl0}, {28'd0, RST0});
        check("rst_cnt0",   {16'd0, sc0}, 32'd0);
        check("rst_flags1", {28'd0, fl1}, {28'd0, RST1});
        drv(1, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        check("rst_eq_fails", {31'd0, ce0}, 32'd0);
        drv(1, 0, 4'd1, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        check("rst_ne_passes", {31'd0, ce0}, 32'd1);

        drv(1, 0, 4'd14, 4'd0, 2'b00, 0, 1, 0, 0, 0);
        check("al_regwrite", {31'd0, rw0}, 32'd1);
        step();
        drv(1, 0, 4'd0, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        check("eq_condex", {31'd0, ce0}, 32'd0);
        step();
        check("squash_one", {16'd0, sc0}, 32'd1);

        drv(1, 0, 4'd14, 4'b0100, 2'b11, 0, 0, 0, 0, 0);
        step();
        check("flags_z", {28'd0, fl0}, 32'h4);
        drv(1, 0, 4'd0, 4'd0, 2'b00, 1, 0, 0, 0, 0);
        check("eq_pcsrc", {31'd0, pc0}, 32'd1);
        step();
        drv(1, 0, 4'd1, 4'd0, 2'b00, 1, 0, 0, 0, 0);
        check("ne_pcsrc", {31'd0, pc0}, 32'd0);
        step();

        drv(1, 0, 4'd14, 4'b1001, 2'b11, 0, 0, 0, 0, 0);
        step();
        drv(1, 0, 4'd14, 4'b0010, 2'b10, 0, 0, 0, 0, 0);
        step();
        check("half_update", {28'd0, fl0}, 32'h1);
        drv(1, 0, 4'd10, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        check("ge_fail", {31'd0, ce0}, 32'd0);
        step();
        drv(1, 0, 4'd11, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        check("lt_pass", {31'd0, ce0}, 32'd1);
        step();

        drv(1, 0, 4'd0, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
        step();
        check("failed_no_update", {28'd0, fl0}, 32'h1);
        drv(1, 0, 4'd15, 4'd0, 2'b00, 0, 0, 1, 0, 0);
        check("nv_memwrite", {31'd0, mw0}, 32'd0);
        step();

        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 4'd0, 4'b1111, 2'b11, 0, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drv(1, 0, 4'd15, 4'd0, 2'b00, 0, 0, 0, 0, 0);
            step();
        end
        check("sat_cnt", {28'd0, sc1}, 32'd15);
        drv(1, 0, 4'd15, 4'd0, 2'b00, 0, 0, 0, 0, 1);
        step();
        check("clr_wins", {16'd0, sc0}, 32'd0);

        drv(1, 0, 4'd14, 4'b1000, 2'b11, 0, 1, 0, 1, 0);
        check("nowrite", {31'd0, rw0}, 32'd0);
        step();
        check("nowrite_flags", {28'd0, fl0}, 32'h8);
        drv(1, 1, 4'd14, 4'd0, 2'b00, 1, 1, 1, 0, 0);
        check("stall_hold_out", {31'd0, rw0}, 32'd1);
        step();

        // Asynchronous reset between clock edges
        drv(1, 0, 4'd15, 4'd0, 2'b00, 0, 0, 0, 0, 0);
        step();
        #3 reset_n = 1'b0;
        #1;
        check("async_flags0", {28'd0, fl0}, {28'd0, RST0});
        check("async_cnt0",   {16'd0, sc0}, 32'd0);
        check("async_flags1", {28'd0, fl1}, {28'd0, RST1});
        model_reset();
        #1 reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            drv(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                4'($urandom), 4'($urandom), 2'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
            step();
        end
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
